ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and decoded `funct3` held in the ID/EX pipeline register and returns one 32-bit result to the EX/MEM register. While an operation is in flight it raises `busy`, which the hazard unit uses to hold PC, IF/ID and ID/EX and to insert a bubble into EX/MEM.

---
 rtl/ex_muldiv_pkg.sv | 15 +
 rtl/ex_muldiv.sv | 87 ++++++++
 tb/tb_ex_muldiv.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// muldiv_pkg: shared RV32M encodings, FSM states and iteration count for ex_muldiv
package muldiv_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    localparam int MULDIV_ITERS = 32;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} md_state_t;
endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide for the EX stage, 34-cycle ops with a 1-cycle fast path
module ex_muldiv import muldiv_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_t state, state_n;
    logic [4:0] cnt;
    logic [63:0] acc, neg64, mul_next, div_next;
    logic [31:0] b_mag, a_abs, b_abs, fast_val, fix_val, lo_f, rem_n;
    logic [32:0] sum, top;
    logic [2:0] f3;
    logic neg_res, a_sgn, b_sgn, neg_a, neg_b, neg_in, fast, ge;
    always_comb begin
        a_sgn = funct3 != F3_MULHU && funct3 != F3_DIVU && funct3 != F3_REMU;
        b_sgn = a_sgn && funct3 != F3_MULHSU;
        neg_a = a_sgn & op_a[31];
        neg_b = b_sgn & op_b[31];
        a_abs = neg_a ? -op_a : op_a;
        b_abs = neg_b ? -op_b : op_b;
        neg_in = funct3 == F3_REM ? neg_a : neg_a ^ neg_b;
        fast = funct3[2] && (op_b == '0 || (!funct3[0] && op_a == 32'h8000_0000 && op_b == '1));
        fast_val = op_b == '0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : 32'h8000_0000);
    end
    // Shared 64-bit accumulator: {partial/remainder, multiplier/dividend-quotient}
    always_comb begin
        sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
        mul_next = {sum, acc[31:1]};
        top = acc[63:31];
        ge = top >= {1'b0, b_mag};
        rem_n = ge ? 32'(top - {1'b0, b_mag}) : top[31:0];
        div_next = {rem_n, acc[30:0], ge};
        neg64 = -acc;
        lo_f = neg_res ? neg64[31:0] : acc[31:0];
        fix_val = (f3 == F3_MUL || f3 == F3_DIV || f3 == F3_DIVU) ? lo_f :
                  !f3[2] ? (neg_res ? neg64[63:32] : acc[63:32]) :
                  (neg_res ? 32'(-acc[63:32]) : acc[63:32]);
    end
    always_ff @(posedge clk)
        state <= rst ? S_IDLE : state_n;
    always_comb begin
        state_n = S_IDLE;
        if (!flush)
            case (state)
                S_IDLE:  state_n = start ? (fast ? S_DONE : S_CALC) : S_IDLE;
                S_CALC:  state_n = cnt == 5'(MULDIV_ITERS - 1) ? S_FIX : S_CALC;
                S_FIX:   state_n = S_DONE;
                default: state_n = S_IDLE;
            endcase
    end
    always_comb
        busy = !rst && ((state == S_IDLE && start && !fast && !flush) || state == S_CALC || state == S_FIX);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            b_mag <= '0;
            f3 <= '0;
            neg_res <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            done <= state_n == S_DONE;
            if (state_n == S_DONE)
                result <= state == S_FIX ? fix_val : fast_val;
            if (state == S_IDLE && start) begin
                cnt <= '0;
                acc <= {32'd0, a_abs};
                b_mag <= b_abs;
                f3 <= funct3;
                neg_res <= neg_in;
            end else if (state == S_CALC) begin
                cnt <= cnt + 5'd1;
                acc <= f3[2] ? div_next : mul_next;
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst, flush, start;
    logic [2:0] funct3;
    logic [31:0] op_a, op_b;
    logic busy, done;
    logic [31:0] result;
    int checks = 0;
    int failures = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint p = 0;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = (ua * ub) >> 32;
            3'd4: p = (b == 0) ? -1 : ovf ? ua : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? ua : ovf ? 0 : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp_r = ref_md(f, a, b);
        bit fast = is_fast(f, a, b);
        int lat_exp = fast ? 1 : 34;
        int got_lat = -1;
        int busy_bad = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        #1;
        if (busy !== !fast) busy_bad++;
        for (int k = 1; k <= 40 && got_lat < 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (done === 1'b1) got_lat = k;
            if (busy !== (!fast && k <= 33)) busy_bad++;
        end
        checks++;
        if (got_lat != lat_exp) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, got_lat, lat_exp);
        end
        checks++;
        if (result !== exp_r) begin
            failures++;
            $display("FAIL %s result f3=%0d a=%h b=%h got=%h exp=%h", name, f, a, b, result, exp_r);
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL %s busy profile bad_cycles=%0d exp=0", name, busy_bad);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset done=%b result=%h busy=%b exp done=0 result=0 busy=0", done, result, busy);
        end
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_directed;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_neg");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_neg");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_neg");
        do_op(3'd5, 32'd100, 32'd7, "divu");
        do_op(3'd7, 32'd100, 32'd7, "remu");
        do_op(3'd4, 32'd5, 32'd0, "div_zero");
        do_op(3'd6, 32'd5, 32'd0, "rem_zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
        return ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom();
    endfunction

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), "random");
    endtask

    task automatic test_flush;
        int got = -1;
        int stray = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done !== 1'b0) stray++;
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_busy_drop got=%b exp=0", busy);
        end
        start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
        for (int k = 12; k <= 60 && got < 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) got = k;
        end
        checks++;
        if (got != 45 || result !== 32'd12 || stray != 0) begin
            failures++;
            $display("FAIL flush_restart done_cycle=%0d result=%h stray=%0d exp cycle=45 result=0000000c stray=0", got, result, stray);
        end
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_busy got=%b exp=0", busy);
        end
        stray = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = 1'b0; flush = 1'b0;
            #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0 || result !== 32'd12) begin
            failures++;
            $display("FAIL flush_start_noop active_cycles=%0d result=%h exp 0 and 0000000c", stray, result);
        end
    endtask

    task automatic test_hold;
        int stray = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            if (k < 34 && done !== 1'b0) stray++;
        end
        checks++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFEB || stray != 0) begin
            failures++;
            $display("FAIL hold_done done=%b result=%h early=%0d exp 1 ffffffeb 0", done, result, stray);
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL hold_no_relaunch busy=%b done=%b exp 0 0", busy, done);
        end
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL hold_quiet done_pulses=%0d exp=0", stray);
        end
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done !== 1'b0) stray++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy_forced got=%b exp=0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || result !== 32'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid done=%b result=%h busy=%b exp 0 0 0", done, result, busy);
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rst_abandon active_cycles=%0d exp=0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
